attopu_exec: RTL and testbench

- Execution core of the attopu 16-bit processor: instruction decoder, 4×16 register file and ALU with registered flags, in one block.
- Sits between the unified instruction/data memory (1024×16) and the PC register, both of which stay in the top level.
- Decodes the current instruction combinationally and drives PC-select, halt, memory address/data/write-enable and register writeback.

---
 rtl/attopu_pkg.sv | 36 +++
 rtl/attopu_alu_core.sv | 44 ++++
 rtl/attopu_regfile.sv | 30 +++
 rtl/attopu_exec.sv | 135 +++++++++++++
 tb/tb_attopu_exec.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/attopu_pkg.sv
// Shared constants for the attopu execution core: opcodes, ALU functions and PC-select codes.
package attopu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_LDR  = 4'h5;
  localparam logic [3:0] OP_STR  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_JR   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_NOT = 3'd5;
  localparam logic [2:0] FN_SHL = 3'd6;
  localparam logic [2:0] FN_SHR = 3'd7;

  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_ABS = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

endpackage

// File: rtl/attopu_alu_core.sv
// Combinational 16-bit ALU producing result and carry/borrow; zero is derived by the caller.
module attopu_alu_core
  import attopu_pkg::*;
(
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [2:0]        func,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, in1} + {1'b0, in2};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (func)
      FN_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      FN_SUB: begin
        result = in1 - in2;
        carry  = (in1 < in2);
      end
      FN_AND: result = in1 & in2;
      FN_OR:  result = in1 | in2;
      FN_XOR: result = in1 ^ in2;
      FN_NOT: result = ~in1;
      FN_SHL: begin
        result = {in1[DATA_W-2:0], 1'b0};
        carry  = in1[DATA_W-1];
      end
      FN_SHR: begin
        result = {1'b0, in1[DATA_W-1:1]};
        carry  = in1[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/attopu_regfile.sv
// 4x16 register file, two combinational read ports and one synchronous write port.
module attopu_regfile
  import attopu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        raddr1,
  input  logic [1:0]        raddr2,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [4];

  // Reads see the pre-edge contents; a write lands on the edge.
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/attopu_exec.sv
// attopu execution core: combinational decoder, register file, ALU and registered carry/zero flags.
module attopu_exec
  import attopu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] memRdata,
  output logic [1:0]        nextPCSel,
  output logic [DATA_W-1:0] addr,
  output logic              halt,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic              memWE,
  output logic [DATA_W-1:0] regOut1,
  output logic [DATA_W-1:0] regOut2,
  output logic              cFlag,
  output logic              zFlag
);

  logic [3:0]        op;
  logic [1:0]        sel1;
  logic [1:0]        sel2;
  logic              regWE;
  logic              flagWE;
  logic              indirect;
  logic [1:0]        wbSel;
  logic [DATA_W-1:0] wbData;
  logic [DATA_W-1:0] aluResult;
  logic              aluCarry;

  assign op = instruction[15:12];

  always_comb begin
    nextPCSel = PCSEL_INC;
    addr      = {6'b0, instruction[9:0]};
    halt      = 1'b0;
    memWE     = 1'b0;
    regWE     = 1'b0;
    flagWE    = 1'b0;
    indirect  = 1'b0;
    wbSel     = WB_ALU;
    sel1      = instruction[9:8];
    sel2      = instruction[7:6];
    case (op)
      OP_ALU: begin
        regWE  = 1'b1;
        flagWE = 1'b1;
      end
      OP_LDI: begin
        regWE = 1'b1;
        wbSel = WB_IMM;
      end
      OP_LD: begin
        regWE = 1'b1;
        wbSel = WB_MEM;
      end
      OP_ST: begin
        memWE = 1'b1;
        sel2  = instruction[11:10];
      end
      OP_LDR: begin
        regWE    = 1'b1;
        wbSel    = WB_MEM;
        indirect = 1'b1;
      end
      OP_STR: begin
        memWE    = 1'b1;
        indirect = 1'b1;
        sel2     = instruction[11:10];
      end
      OP_JMP: begin
        addr      = {4'b0, instruction[11:0]};
        nextPCSel = PCSEL_ABS;
      end
      OP_JZ: begin
        addr      = {4'b0, instruction[11:0]};
        nextPCSel = zFlag ? PCSEL_ABS : PCSEL_INC;
      end
      OP_JC: begin
        addr      = {4'b0, instruction[11:0]};
        nextPCSel = cFlag ? PCSEL_ABS : PCSEL_INC;
      end
      OP_JR: begin
        nextPCSel = PCSEL_REG;
        sel1      = instruction[11:10];
      end
      OP_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (wbSel)
      WB_IMM:  wbData = addr;
      WB_MEM:  wbData = memRdata;
      default: wbData = aluResult;
    endcase
  end

  assign memAddr  = indirect ? regOut1 : addr;
  assign memWdata = regOut2;

  attopu_regfile uRegfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (sel1),
    .raddr2 (sel2),
    .we     (regWE),
    .waddr  (instruction[11:10]),
    .wdata  (wbData),
    .rdata1 (regOut1),
    .rdata2 (regOut2)
  );

  attopu_alu_core uAlu (
    .in1    (regOut1),
    .in2    (regOut2),
    .func   (instruction[2:0]),
    .result (aluResult),
    .carry  (aluCarry)
  );

  // Flags hold across non-ALU instructions so conditional jumps see the last ALU result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cFlag <= 1'b0;
      zFlag <= 1'b0;
    end else if (flagWE) begin
      cFlag <= aluCarry;
      zFlag <= (aluResult == '0);
    end
  end

endmodule

// File: tb/tb_attopu_exec.sv
// Directed bench for attopu_exec: hand-computed vectors checked with immediate assertions.
module tb_attopu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic [15:0] memRdata;
  logic [1:0]  nextPCSel;
  logic [15:0] addr;
  logic        halt;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memWE;
  logic [15:0] regOut1;
  logic [15:0] regOut2;
  logic        cFlag;
  logic        zFlag;

  int vectors = 0;
  int miscompares = 0;

  attopu_exec dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .memRdata    (memRdata),
    .nextPCSel   (nextPCSel),
    .addr        (addr),
    .halt        (halt),
    .memAddr     (memAddr),
    .memWdata    (memWdata),
    .memWE       (memWE),
    .regOut1     (regOut1),
    .regOut2     (regOut2),
    .cFlag       (cFlag),
    .zFlag       (zFlag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an instruction and let the combinational outputs settle.
  task automatic present(input logic [15:0] instr);
    instruction = instr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // NOP whose default read selects expose two registers on the ports.
  task automatic readRegs(input logic [1:0] a, input logic [1:0] b,
                          input logic [15:0] expA, input logic [15:0] expB, input string tag);
    present({4'h0, 2'b00, a, b, 6'b0});
    chk({tag, "_p1"}, regOut1, expA);
    chk({tag, "_p2"}, regOut2, expB);
  endtask

  task automatic chkFlags(input logic c, input logic z, input string tag);
    chk({tag, "_c"}, {15'b0, cFlag}, {15'b0, c});
    chk({tag, "_z"}, {15'b0, zFlag}, {15'b0, z});
  endtask

  initial begin
    rst = 1'b1;
    instruction = 16'h0000;
    memRdata = 16'h0000;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    readRegs(2'd0, 2'd1, 16'h0000, 16'h0000, "rst_r0r1");
    readRegs(2'd2, 2'd3, 16'h0000, 16'h0000, "rst_r2r3");
    chkFlags(1'b0, 1'b0, "rst_flags");

    // LDI r1,#0x3FF
    present(16'h27FF);
    chk("ldi_pcsel", {14'b0, nextPCSel}, 16'h0000);
    chk("ldi_we", {15'b0, memWE}, 16'h0000);
    tick();
    readRegs(2'd1, 2'd0, 16'h03FF, 16'h0000, "ldi_r1");
    chkFlags(1'b0, 1'b0, "ldi_flags");

    // r1 = NOT r0 = 0xFFFF, r2 = 1, ADD r0,r1,r2
    present(16'h1405); tick();
    present(16'h2801); tick();
    readRegs(2'd1, 2'd2, 16'hFFFF, 16'h0001, "pre_add");
    present(16'h1180); tick();
    readRegs(2'd0, 2'd1, 16'h0000, 16'hFFFF, "add_r0");
    chkFlags(1'b1, 1'b1, "add_flags");
    present(16'h8123);
    chk("jz_taken_sel", {14'b0, nextPCSel}, 16'h0001);
    chk("jz_addr", addr, 16'h0123);
    present(16'h9456);
    chk("jc_taken_sel", {14'b0, nextPCSel}, 16'h0001);
    present(16'h7FFF);
    chk("jmp_addr12", addr, 16'h0FFF);
    chk("jmp_sel", {14'b0, nextPCSel}, 16'h0001);

    // SUB r3,r1,r2 with r1=2, r2=5; LDI must not touch flags
    present(16'h2402); tick();
    present(16'h2805); tick();
    chkFlags(1'b1, 1'b1, "ldi_hold");
    present(16'h1D81); tick();
    readRegs(2'd3, 2'd0, 16'hFFFD, 16'h0000, "sub_r3");
    chkFlags(1'b1, 1'b0, "sub_flags");
    present(16'h8123);
    chk("jz_not_taken", {14'b0, nextPCSel}, 16'h0000);
    present(16'h2000); tick();
    chkFlags(1'b1, 1'b0, "ldi_hold2");

    // ST r2 -> 0x010
    present(16'h4810);
    chk("st_we", {15'b0, memWE}, 16'h0001);
    chk("st_addr", memAddr, 16'h0010);
    chk("st_wdata", memWdata, 16'h0005);
    tick();

    // STR r2 via r1 = 0x20, then LDR r3 via r1
    present(16'h2420); tick();
    present(16'h6900);
    chk("str_we", {15'b0, memWE}, 16'h0001);
    chk("str_addr", memAddr, 16'h0020);
    chk("str_wdata", memWdata, 16'h0005);
    memRdata = 16'hBEEF;
    present(16'h5D00);
    chk("ldr_addr", memAddr, 16'h0020);
    chk("ldr_we", {15'b0, memWE}, 16'h0000);
    tick();
    memRdata = 16'h0000;
    readRegs(2'd3, 2'd1, 16'hBEEF, 16'h0020, "ldr_r3");

    // ADD r1,r1,r1: same-cycle read sees old value
    present(16'h1540);
    chk("rbw_old", regOut1, 16'h0020);
    tick();
    readRegs(2'd1, 2'd0, 16'h0040, 16'h0000, "rbw_new");
    chkFlags(1'b0, 1'b0, "add2_flags");

    // JR r2 with r2 = 0x40
    present(16'h2840); tick();
    present(16'hA800);
    chk("jr_sel", {14'b0, nextPCSel}, 16'h0002);
    chk("jr_port1", regOut1, 16'h0040);

    // HALT: no writes
    present(16'hF000);
    chk("halt", {15'b0, halt}, 16'h0001);
    chk("halt_we", {15'b0, memWE}, 16'h0000);
    chk("halt_sel", {14'b0, nextPCSel}, 16'h0000);
    tick();
    readRegs(2'd0, 2'd1, 16'h0000, 16'h0040, "halt_r0r1");
    readRegs(2'd2, 2'd3, 16'h0040, 16'hBEEF, "halt_r2r3");

    // SUB r0,r0,r1 sets carry; opcode 0xB then acts as NOP
    present(16'h1041); tick();
    chkFlags(1'b1, 1'b0, "sub2_flags");
    present(16'hBD81);
    chk("opB_we", {15'b0, memWE}, 16'h0000);
    chk("opB_halt", {15'b0, halt}, 16'h0000);
    chk("opB_sel", {14'b0, nextPCSel}, 16'h0000);
    tick();
    readRegs(2'd3, 2'd0, 16'hBEEF, 16'hFFC0, "opB_regs");
    chkFlags(1'b1, 1'b0, "opB_flags");

    // Mid-program reset with a pending LDI and an ALU op that would set flags
    rst = 1'b1;
    present(16'h2455);
    tick();
    present(16'h1180);
    tick();
    rst = 1'b0;
    readRegs(2'd0, 2'd1, 16'h0000, 16'h0000, "mrst_r0r1");
    readRegs(2'd2, 2'd3, 16'h0000, 16'h0000, "mrst_r2r3");
    chkFlags(1'b0, 1'b0, "mrst_flags");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
